// File: rtl/rvfi_check_sequencer.sv
// rvfi_check_sequencer
// Runs one check pass around a core under test. The core is held in reset for
// a fixed number of cycles. The sequencer then watches the RVFI retire stream
// on one channel and emits a single-cycle `check` strobe at the first
// qualifying retirement. If no qualifying retirement arrives within DEPTH run
// cycles, the run ends in a sticky timeout instead.

module rvfi_check_sequencer #(
  parameter int          NRET         = 1,
  parameter int          CHANNEL      = 0,
  parameter int          RESET_CYCLES = 1,
  parameter logic [63:0] MIN_ORDER    = 64'd0,
  parameter int          DEPTH        = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 check_enable,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [64*NRET-1:0]   rvfi_order,
  output logic                 core_reset,
  output logic                 check,
  output logic                 done,
  output logic                 timeout,
  output logic [15:0]          cycle,
  output logic [15:0]          retired
);

  // The reset counter only needs to reach RESET_CYCLES-1.
  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RCW-1:0] RC_LAST = RCW'(RESET_CYCLES - 1);

  // The last run cycle in which a hit is still accepted.
  localparam logic [15:0] CYCLE_LAST = 16'(DEPTH - 1);

  // Wide enough to hold a count of 0..NRET set bits.
  localparam int PCW = $clog2(NRET + 1);

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t           state;
  logic [RCW-1:0]   rst_cnt;
  logic [63:0]      order;
  logic             hit;
  logic [PCW-1:0]   valid_count;
  logic [16:0]      retired_sum;
  logic [15:0]      retired_next;
  logic             unused_order;

  // Counts the retire-valid bits in one cycle.
  function automatic logic [PCW-1:0] popcount(input logic [NRET-1:0] v);
    logic [PCW-1:0] n;
    n = '0;
    for (int i = 0; i < NRET; i++) begin
      n = n + PCW'(v[i]);
    end
    return n;
  endfunction

  // Only the selected channel's order is compared. The other channels' order
  // fields are intentionally ignored.
  assign order        = rvfi_order[64*CHANNEL +: 64];
  assign unused_order = ^rvfi_order;

  // A qualifying retirement on the selected channel. The order field is
  // looked at only behind a valid retire, so undriven order bits never leak
  // into the result.
  always_comb begin
    hit = 1'b0;
    if (check_enable && rvfi_valid[CHANNEL]) begin
      if (order >= MIN_ORDER) begin
        hit = 1'b1;
      end else begin
        hit = 1'b0;
      end
    end else begin
      hit = 1'b0;
    end
  end

  // Saturating update of the retirement total for this cycle.
  always_comb begin
    valid_count  = popcount(rvfi_valid);
    retired_sum  = {1'b0, retired} + 17'(valid_count);
    retired_next = retired_sum[15:0];
    if (retired_sum[16]) begin
      retired_next = 16'hFFFF;
    end else begin
      retired_next = retired_sum[15:0];
    end
  end

  // The check strobe is combinational so that checkers sample the live RVFI
  // retirement. It is suppressed while reset is asserted.
  always_comb begin
    check = 1'b0;
    if ((state == S_RUN) && hit && !reset) begin
      check = 1'b1;
    end else begin
      check = 1'b0;
    end
  end

  // Sequencer: hold the core in reset, run the watch window, then park in a
  // terminal state until the next reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_RESET;
      rst_cnt    <= '0;
      cycle      <= 16'd0;
      retired    <= 16'd0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      case (state)
        S_RESET: begin
          core_reset <= 1'b1;
          if (rst_cnt == RC_LAST) begin
            state      <= S_RUN;
            core_reset <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + RCW'(1);
          end
        end
        S_RUN: begin
          core_reset <= 1'b0;
          retired    <= retired_next;
          if (hit) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (cycle == CYCLE_LAST) begin
            state   <= S_TIMEOUT;
            timeout <= 1'b1;
          end else begin
            cycle <= cycle + 16'd1;
          end
        end
        S_DONE: begin
          core_reset <= 1'b0;
          done       <= 1'b1;
          timeout    <= 1'b0;
        end
        S_TIMEOUT: begin
          core_reset <= 1'b0;
          done       <= 1'b0;
          timeout    <= 1'b1;
        end
        default: begin
          state      <= S_RESET;
          rst_cnt    <= '0;
          cycle      <= 16'd0;
          retired    <= 16'd0;
          done       <= 1'b0;
          timeout    <= 1'b0;
          core_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Testbench for rvfi_check_sequencer.
// Each scenario fills a per-cycle stimulus table. Expected outputs come from a
// run-level model: find the first qualifying run cycle, then derive every
// output from its distance to that point.

module tb_rvfi_check_sequencer;

  localparam int          NRET      = 2;
  localparam int          CHANNEL   = 1;
  localparam int          RC        = 3;
  localparam int          DEPTH     = 20;
  localparam logic [63:0] MIN_ORDER = 64'd10;
  localparam int          NCYC      = 30;

  logic               clock;
  logic               reset;
  logic               check_enable;
  logic [NRET-1:0]    rvfi_valid;
  logic [64*NRET-1:0] rvfi_order;
  logic               core_reset;
  logic               check;
  logic               done;
  logic               timeout;
  logic [15:0]        cycle;
  logic [15:0]        retired;

  // Stimulus table, indexed by cycles since the reset edge.
  logic        st_en    [NCYC];
  logic [1:0]  st_valid [NCYC];
  logic [63:0] st_o0    [NCYC];
  logic [63:0] st_o1    [NCYC];

  int errors = 0;
  int checks = 0;

  rvfi_check_sequencer #(
    .NRET(NRET), .CHANNEL(CHANNEL), .RESET_CYCLES(RC),
    .MIN_ORDER(MIN_ORDER), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .check_enable(check_enable),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .core_reset(core_reset), .check(check), .done(done),
    .timeout(timeout), .cycle(cycle), .retired(retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected {core_reset, check, done, timeout, cycle, retired} at cycle t.
  function automatic logic [35:0] model(int t);
    int   h;
    int   k;
    int   last;
    int   ret;
    int   cyc;
    logic cr, chk, dn, to;
    h = -1;
    for (int j = 0; j < DEPTH; j++) begin
      if (h < 0 && st_en[RC+j] && st_valid[RC+j][CHANNEL]) begin
        if (st_o1[RC+j] >= MIN_ORDER) h = j;
      end
    end
    k    = t - RC;
    last = (h >= 0) ? h : DEPTH - 1;
    cr   = (t < RC);
    chk  = (k >= 0) && (k == h);
    dn   = (h >= 0) && (k > h);
    to   = (h < 0) && (k > last);
    cyc  = (k < 0) ? 0 : ((k > last) ? last : k);
    ret  = 0;
    for (int j = 0; j < k && j <= last; j++) ret += $countones(st_valid[RC+j]);
    if (ret > 65535) ret = 65535;
    return {cr, chk, dn, to, 16'(cyc), 16'(ret)};
  endfunction

  task automatic clear_stim();
    for (int t = 0; t < NCYC; t++) begin
      st_en[t]    = 1'b1;
      st_valid[t] = 2'b00;
      st_o0[t]    = 'x;
      st_o1[t]    = 'x;
    end
  endtask

  task automatic drive(int t);
    check_enable = st_en[t];
    rvfi_valid   = st_valid[t];
    rvfi_order   = {st_o1[t], st_o0[t]};
  endtask

  // One-cycle reset with inputs that would otherwise hit.
  task automatic apply_reset();
    reset        = 1'b1;
    check_enable = 1'b1;
    rvfi_valid   = 2'b11;
    rvfi_order   = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [35:0] got, exp;
    clear_stim();
    apply_reset();
    for (int t = 0; t < NCYC; t++) begin
      drive(t);
      @(negedge clock);
      got = {core_reset, check, done, timeout, cycle, retired};
      exp = model(t);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_timeout t=%0d got=%h exp=%h", t, got, exp);
      end
      @(posedge clock);
      #1;
    end
    checks++;
    if (timeout !== 1'b1 || done !== 1'b0 || retired !== 16'd0 || cycle !== 16'd19) begin
      errors++;
      $display("FAIL reset_final got to=%b dn=%b ret=%0d cyc=%0d exp to=1 dn=0 ret=0 cyc=19",
               timeout, done, retired, cycle);
    end
  endtask

  task automatic test_single_hit();
    logic [35:0] got, exp;
    clear_stim();
    st_valid[RC+5] = 2'b10;
    st_o1[RC+5]    = 64'd4 + 64'($urandom_range(6, 100));
    apply_reset();
    for (int t = 0; t < NCYC; t++) begin
      drive(t);
      @(negedge clock);
      got = {core_reset, check, done, timeout, cycle, retired};
      exp = model(t);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_hit t=%0d got=%h exp=%h", t, got, exp);
      end
      @(posedge clock);
      #1;
    end
    checks++;
    if (done !== 1'b1 || cycle !== 16'd5 || retired !== 16'd1) begin
      errors++;
      $display("FAIL single_hit_final got dn=%b cyc=%0d ret=%0d exp dn=1 cyc=5 ret=1",
               done, cycle, retired);
    end
  endtask

  task automatic test_min_order();
    logic [35:0] got, exp;
    clear_stim();
    for (int i = 0; i < 3; i++) begin
      st_valid[RC+2+i] = 2'b10;
      st_o1[RC+2+i]    = 64'(8 + i);
    end
    apply_reset();
    for (int t = 0; t < NCYC; t++) begin
      drive(t);
      @(negedge clock);
      got = {core_reset, check, done, timeout, cycle, retired};
      exp = model(t);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL min_order t=%0d got=%h exp=%h", t, got, exp);
      end
      @(posedge clock);
      #1;
    end
    checks++;
    if (retired !== 16'd3 || cycle !== 16'd4) begin
      errors++;
      $display("FAIL min_order_final got ret=%0d cyc=%0d exp ret=3 cyc=4", retired, cycle);
    end
  endtask

  task automatic test_enable_gating();
    logic [35:0] got, exp;
    clear_stim();
    for (int t = 0; t < NCYC; t++) begin
      st_valid[t] = 2'b11;
      st_o0[t]    = 64'hFFFF_0000_0000_0000 | 64'($urandom);
      st_o1[t]    = (t >= RC + 2) ? 64'($urandom_range(10, 500)) : 64'd0;
      st_en[t]    = (t >= RC + 4);
    end
    apply_reset();
    for (int t = 0; t < NCYC; t++) begin
      drive(t);
      @(negedge clock);
      got = {core_reset, check, done, timeout, cycle, retired};
      exp = model(t);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL enable_gating t=%0d got=%h exp=%h", t, got, exp);
      end
      @(posedge clock);
      #1;
    end
    checks++;
    if (retired !== 16'd10 || cycle !== 16'd4 || done !== 1'b1) begin
      errors++;
      $display("FAIL enable_gating_final got ret=%0d cyc=%0d dn=%b exp ret=10 cyc=4 dn=1",
               retired, cycle, done);
    end
  endtask

  task automatic test_depth_boundary();
    logic [35:0] got, exp;
    clear_stim();
    st_valid[RC+DEPTH-1] = 2'b10;
    st_o1[RC+DEPTH-1]    = MIN_ORDER;
    apply_reset();
    for (int t = 0; t < NCYC; t++) begin
      drive(t);
      @(negedge clock);
      got = {core_reset, check, done, timeout, cycle, retired};
      exp = model(t);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL depth_boundary t=%0d got=%h exp=%h", t, got, exp);
      end
      @(posedge clock);
      #1;
    end
    checks++;
    if (done !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL depth_boundary_final got dn=%b to=%b exp dn=1 to=0", done, timeout);
    end
  endtask

  task automatic test_midrun_reset();
    logic [35:0] got, exp;
    clear_stim();
    for (int t = 0; t < NCYC; t++) st_valid[t] = {1'b0, 1'($urandom_range(0, 1))};
    apply_reset();
    for (int t = 0; t < RC + 5; t++) begin
      drive(t);
      @(negedge clock);
      got = {core_reset, check, done, timeout, cycle, retired};
      exp = model(t);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL midrun_pre t=%0d got=%h exp=%h", t, got, exp);
      end
      @(posedge clock);
      #1;
    end
    reset        = 1'b1;
    check_enable = 1'b1;
    rvfi_valid   = 2'b11;
    rvfi_order   = {64'd50, 64'd50};
    @(negedge clock);
    checks++;
    if (check !== 1'b0) begin
      errors++;
      $display("FAIL midrun_check_in_reset got=%b exp=0", check);
    end
    clear_stim();
    st_valid[RC+2] = 2'b11;
    st_o0[RC+2]    = 64'd0;
    st_o1[RC+2]    = 64'd77;
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int t = 0; t < NCYC; t++) begin
      drive(t);
      @(negedge clock);
      got = {core_reset, check, done, timeout, cycle, retired};
      exp = model(t);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL midrun_post t=%0d got=%h exp=%h", t, got, exp);
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_random();
    logic [35:0] got, exp;
    for (int it = 0; it < 10; it++) begin
      clear_stim();
      for (int t = 0; t < NCYC; t++) begin
        st_en[t]       = ($urandom_range(0, 3) != 0);
        st_valid[t][0] = 1'($urandom_range(0, 1));
        st_valid[t][1] = ($urandom_range(0, 6) == 0);
        if (st_valid[t][0]) st_o0[t] = {$urandom, $urandom};
        if (st_valid[t][1]) begin
          case ($urandom_range(0, 4))
            0, 1:    st_o1[t] = 64'($urandom_range(0, 9));
            2:       st_o1[t] = 64'($urandom_range(10, 12));
            3:       st_o1[t] = {32'd1, 32'd3};
            default: st_o1[t] = {$urandom, $urandom};
          endcase
        end
      end
      apply_reset();
      for (int t = 0; t < NCYC; t++) begin
        drive(t);
        @(negedge clock);
        got = {core_reset, check, done, timeout, cycle, retired};
        exp = model(t);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL random it=%0d t=%0d got=%h exp=%h", it, t, got, exp);
        end
        @(posedge clock);
        #1;
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    check_enable = 1'b0;
    rvfi_valid   = '0;
    rvfi_order   = '0;
    @(posedge clock);
    #1;
    test_reset();
    test_single_hit();
    test_min_order();
    test_enable_gating();
    test_depth_boundary();
    test_midrun_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
